ldpc_iter_sched: RTL

LDPC_ITER_SCHED -- requirements
Module: ldpc_iter_sched

---
 rtl/ldpc_iter_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ldpc_iter_sched.sv
// LDPC iteration scheduler: sequences INIT, ROW/COL message passes and the parity CHECK, driving both message-SRAM address ports.
// Latency: INIT N_ENTRY cycles, each iteration 2*(N_ENTRY+2)+1 cycles, then a 1-cycle DONE pulse.
// Backpressure: none; i_val is only honoured in IDLE. Build option: define LDPC_SCHED_EARLY_TERM_EN to stop on parity.
module ldpc_iter_sched #(
    parameter int N_ENTRY  = 16,
    parameter int LOOP_MAX = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_val,
    input  logic       i_parity_ok,
    output logic       o_busy,
    output logic [1:0] o_phase,
    output logic [7:0] o_raddr_alpha,
    output logic [7:0] o_waddr_alpha,
    output logic [7:0] o_raddr_beta,
    output logic [7:0] o_waddr_beta,
    output logic       o_wen_alpha,
    output logic       o_wen_beta,
    output logic [6:0] o_loop,
    output logic       o_done,
    output logic       o_converged
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ROW,
        S_COL,
        S_CHECK,
        S_DONE
    } state_t;

    // Phase counter needs 9 bits: a ROW/COL pass runs N_ENTRY+2 cycles (up to 258).
    localparam logic [8:0] INIT_LAST  = 9'(N_ENTRY - 1);
    localparam logic [8:0] PASS_LAST  = 9'(N_ENTRY + 1);
    localparam logic [8:0] RD_END     = 9'(N_ENTRY);
    localparam logic [8:0] WR_START   = 9'd2;
    localparam logic [6:0] LOOP_LAST  = 7'(LOOP_MAX - 1);

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [6:0] loop_q, loop_d;
    logic       conv_q, conv_d;
    logic       last_iter;
    logic       terminate;
    logic [7:0] wr_addr;

    // Writes trail reads by two cycles: one SRAM read latency plus one datapath register.
    assign wr_addr = cnt_q[7:0] - 8'd2;

    // Termination decision evaluated while in CHECK.
    always_comb begin
        last_iter = (loop_q == LOOP_LAST);
`ifdef LDPC_SCHED_EARLY_TERM_EN
        terminate = last_iter || i_parity_ok;
`else
        terminate = last_iter;
`endif
    end

    // Next-state, counters and decoded memory controls.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        loop_d        = loop_q;
        conv_d        = conv_q;
        o_phase       = 2'd0;
        o_raddr_alpha = 8'd0;
        o_waddr_alpha = 8'd0;
        o_raddr_beta  = 8'd0;
        o_waddr_beta  = 8'd0;
        o_wen_alpha   = 1'b0;
        o_wen_beta    = 1'b0;
        o_done        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_val) begin
                    state_d = S_INIT;
                    cnt_d   = 9'd0;
                    loop_d  = 7'd0;
                    conv_d  = 1'b0;
                end
            end
            S_INIT: begin
                o_phase      = 2'd1;
                o_wen_beta   = 1'b1;
                o_waddr_beta = cnt_q[7:0];
                if (cnt_q == INIT_LAST) begin
                    state_d = S_ROW;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_ROW: begin
                o_phase = 2'd2;
                if (cnt_q < RD_END) begin
                    o_raddr_beta = cnt_q[7:0];
                end
                if (cnt_q >= WR_START) begin
                    o_wen_alpha   = 1'b1;
                    o_waddr_alpha = wr_addr;
                end
                if (cnt_q == PASS_LAST) begin
                    state_d = S_COL;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_COL: begin
                o_phase = 2'd3;
                if (cnt_q < RD_END) begin
                    o_raddr_alpha = cnt_q[7:0];
                end
                if (cnt_q >= WR_START) begin
                    o_wen_beta   = 1'b1;
                    o_waddr_beta = wr_addr;
                end
                if (cnt_q == PASS_LAST) begin
                    state_d = S_CHECK;
                    cnt_d   = 9'd0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            S_CHECK: begin
                loop_d = loop_q + 7'd1;
                if (terminate) begin
                    state_d = S_DONE;
                    conv_d  = i_parity_ok;
                end else begin
                    state_d = S_ROW;
                    cnt_d   = 9'd0;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 9'd0;
            loop_q  <= 7'd0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loop_q  <= loop_d;
            conv_q  <= conv_d;
        end
    end

    assign o_busy      = (state_q != S_IDLE);
    assign o_loop      = loop_q;
    assign o_converged = conv_q;

endmodule
